// File: rtl/coffee_brew_sequencer_pkg.sv
// Shared types and constants for the coffee brew sequencer slice.
package coffee_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CUP_WAIT = 4'd1,
    ST_HEAT     = 4'd2,
    ST_GRIND    = 4'd3,
    ST_BREW     = 4'd4,
    ST_DRIP     = 4'd5,
    ST_DONE     = 4'd6,
    ST_REARM    = 4'd7,
    ST_FAULT    = 4'd8
  } state_t;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_NO_CUP       = 3'd1;
  localparam logic [2:0] FC_HEAT_TIMEOUT = 3'd2;
  localparam logic [2:0] FC_WATER_LOW    = 3'd3;
  localparam logic [2:0] FC_CUP_REMOVED  = 3'd4;

  localparam int unsigned DEF_TICK_DIV        = 100000;
  localparam int unsigned DEF_GRIND_MS        = 3000;
  localparam int unsigned DEF_BREW_MS         = 5000;
  localparam int unsigned DEF_DRIP_MS         = 1000;
  localparam int unsigned DEF_CUP_TIMEOUT_MS  = 5000;
  localparam int unsigned DEF_HEAT_TIMEOUT_MS = 10000;

  // A phase of n ticks ends on the last tick of its n-th millisecond.
  function automatic logic phase_done(input logic tick, input logic [15:0] cnt,
                                      input int unsigned n);
    return tick && (cnt == 16'(n - 1));
  endfunction

endpackage

// File: rtl/coffee_brew_sequencer_ms_tick_gen.sv
// Prescaler producing a 1-cycle tick every TICK_DIV clocks, restartable by clear.
module ms_tick_gen
  import coffee_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);

  logic [W-1:0] count;

  assign tick = (count == W'(TICK_DIV - 1));

  // Count clocks, wrapping on tick; clear restarts the millisecond from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/coffee_brew_sequencer.sv
// Sequences cup check, heating, grinding, pumping and drip for one cup per request.
module coffee_brew_sequencer
  import coffee_pkg::*;
#(
  parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
  parameter int unsigned GRIND_MS        = DEF_GRIND_MS,
  parameter int unsigned BREW_MS         = DEF_BREW_MS,
  parameter int unsigned DRIP_MS         = DEF_DRIP_MS,
  parameter int unsigned CUP_TIMEOUT_MS  = DEF_CUP_TIMEOUT_MS,
  parameter int unsigned HEAT_TIMEOUT_MS = DEF_HEAT_TIMEOUT_MS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       brew_req,
  input  logic       cup_present,
  input  logic       temp_ok,
  input  logic       water_ok,
  input  logic       fault_clr,
  output logic       heater_on,
  output logic       grinder_on,
  output logic       pump_on,
  output logic       coffee_out,
  output logic       busy,
  output logic       fault,
  output logic [2:0] fault_code
);

  state_t      state;
  state_t      next_state;
  logic [2:0]  next_code;
  logic        state_change;
  logic        tick;
  logic [15:0] cnt;

  assign state_change = (next_state != state);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state_change),
    .tick  (tick)
  );

  // Millisecond counter for the current phase; restarts whenever the state moves.
  always_ff @(posedge clk) begin
    if (reset || state_change) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Next-state selection; abort beats faults, faults beat progress, progress beats timeout.
  always_comb begin
    next_state = state;
    next_code  = FC_NONE;
    case (state)
      ST_IDLE: begin
        if (brew_req) next_state = ST_CUP_WAIT;
      end
      ST_CUP_WAIT: begin
        if (!brew_req) begin
          next_state = ST_IDLE;
        end else if (cup_present) begin
          next_state = ST_HEAT;
        end else if (phase_done(tick, cnt, CUP_TIMEOUT_MS)) begin
          next_state = ST_FAULT;
          next_code  = FC_NO_CUP;
        end
      end
      ST_HEAT: begin
        if (!brew_req) begin
          next_state = ST_IDLE;
        end else if (!water_ok) begin
          next_state = ST_FAULT;
          next_code  = FC_WATER_LOW;
        end else if (!cup_present) begin
          next_state = ST_FAULT;
          next_code  = FC_CUP_REMOVED;
        end else if (temp_ok) begin
          next_state = ST_GRIND;
        end else if (phase_done(tick, cnt, HEAT_TIMEOUT_MS)) begin
          next_state = ST_FAULT;
          next_code  = FC_HEAT_TIMEOUT;
        end
      end
      ST_GRIND: begin
        if (!brew_req) begin
          next_state = ST_IDLE;
        end else if (!water_ok) begin
          next_state = ST_FAULT;
          next_code  = FC_WATER_LOW;
        end else if (!cup_present) begin
          next_state = ST_FAULT;
          next_code  = FC_CUP_REMOVED;
        end else if (phase_done(tick, cnt, GRIND_MS)) begin
          next_state = ST_BREW;
        end
      end
      ST_BREW: begin
        if (!brew_req) begin
          next_state = ST_IDLE;
        end else if (!water_ok) begin
          next_state = ST_FAULT;
          next_code  = FC_WATER_LOW;
        end else if (!cup_present) begin
          next_state = ST_FAULT;
          next_code  = FC_CUP_REMOVED;
        end else if (phase_done(tick, cnt, BREW_MS)) begin
          next_state = ST_DRIP;
        end
      end
      ST_DRIP: begin
        if (phase_done(tick, cnt, DRIP_MS)) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_REARM;
      end
      ST_REARM: begin
        if (!brew_req) next_state = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr && !brew_req) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs decoded from the incoming state so they switch on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      heater_on  <= 1'b0;
      grinder_on <= 1'b0;
      pump_on    <= 1'b0;
      coffee_out <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      heater_on  <= (next_state == ST_HEAT) || (next_state == ST_GRIND) ||
                    (next_state == ST_BREW);
      grinder_on <= (next_state == ST_GRIND);
      pump_on    <= (next_state == ST_BREW);
      coffee_out <= (next_state == ST_DONE);
      busy       <= (next_state != ST_IDLE);
      fault      <= (next_state == ST_FAULT);
      if (next_state == ST_FAULT) begin
        if (state != ST_FAULT) fault_code <= next_code;
      end else begin
        fault_code <= FC_NONE;
      end
    end
  end

endmodule
